// File: rtl/mdac_pkg.sv
// Shared definitions for the MDAC serial transmit path: FSM encodings and
// the serial-clock divider legality rule.
package mdac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  // An even divider keeps sclk high and low halves equal.
  function automatic bit div_legal(input int div);
    return (div >= 2) && (div % 2 == 0);
  endfunction

endpackage

// File: rtl/mdac_div_counter.sv
// Serial-bit phase counter: divides clk by DIV, produces the registered
// serial clock level and a tick on the last phase of each bit.
module mdac_div_counter
  import mdac_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  output logic [$clog2(DIV)-1:0] phase,
  output logic                   sclk_level,
  output logic                   bit_tick
);

  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] PH_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] PH_HALF = PW'(DIV / 2);

  if (!div_legal(DIV)) begin : g_div_illegal
    $error("mdac_div_counter: DIV must be even and at least 2");
  end

  logic [PW-1:0] phase_nxt;

  assign bit_tick  = (phase == PH_LAST);
  assign phase_nxt = bit_tick ? '0 : phase + 1'b1;

  // sclk is registered from the next phase so it lines up with phase itself.
  always_ff @(posedge clk) begin
    if (reset || !en) begin
      phase      <= '0;
      sclk_level <= 1'b0;
    end else begin
      phase      <= phase_nxt;
      sclk_level <= (phase_nxt >= PH_HALF);
    end
  end

endmodule

// File: rtl/mdac_serial_tx.sv
// Parallel-to-serial MDAC word transmitter: MSB-first shift inside an
// active-low frame strobe, closed by a one-cycle latch phase.
module mdac_serial_tx
  import mdac_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             sdo,
  output logic             sclk_out,
  output logic             sync_n,
  output logic             done,
  output logic             busy
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [$clog2(DIV)-1:0] PH_LAST = $clog2(DIV)'(DIV - 1);

  if (WIDTH < 2) begin : g_width_illegal
    $error("mdac_serial_tx: WIDTH must be at least 2");
  end

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   shreg, shreg_nxt;
  logic [BW-1:0]      bit_cnt, bit_cnt_nxt;
  logic [$clog2(DIV)-1:0] phase;
  logic               bit_tick;

  mdac_div_counter #(.DIV(DIV)) u_div (
    .clk       (clk),
    .reset     (reset),
    .en        (state == ST_SHIFT),
    .phase     (phase),
    .sclk_level(sclk_out),
    .bit_tick  (bit_tick)
  );

  assign in_ready = (state == ST_IDLE) && !reset;

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    case (state)
      ST_IDLE: begin
        bit_cnt_nxt = '0;
        if (in_valid && in_ready) begin
          shreg_nxt = in_data;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bit_tick) begin
          shreg_nxt   = {shreg[WIDTH-2:0], 1'b0};
          bit_cnt_nxt = bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) state_nxt = ST_LATCH;
        end
      end
      ST_LATCH: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they switch together
  // with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      sdo     <= 1'b0;
      sync_n  <= 1'b1;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      bit_cnt <= bit_cnt_nxt;
      sdo     <= (state_nxt == ST_SHIFT) && shreg_nxt[WIDTH-1];
      sync_n  <= (state_nxt != ST_SHIFT);
      done    <= (state_nxt == ST_LATCH);
      busy    <= (state_nxt != ST_IDLE);
    end
  end

  a_tick_at_last_phase: assert property (@(posedge clk) disable iff (reset)
    bit_tick |-> (phase == PH_LAST));

endmodule

// File: tb/tb_mdac_serial_tx.sv
// Bench for mdac_serial_tx: random and directed frames checked cycle by
// cycle against a timing model built from the frame arithmetic.
module tb_mdac_serial_tx;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int FL = W * D;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic valid = 1'b0;
  logic [W-1:0] data = '0;
  logic ready, sdo, sclk, sync_n, done, busy;
  logic valid2 = 1'b0;
  logic [1:0] data2 = '0;
  logic ready2, sdo2, sclk2, sync2, done2, busy2;
  int cyc = 0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mdac_serial_tx #(.WIDTH(W), .DIV(D)) dut (
    .clk(clk), .reset(reset), .in_valid(valid), .in_ready(ready),
    .in_data(data), .sdo(sdo), .sclk_out(sclk), .sync_n(sync_n),
    .done(done), .busy(busy)
  );

  mdac_serial_tx #(.WIDTH(2), .DIV(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(valid2), .in_ready(ready2),
    .in_data(data2), .sdo(sdo2), .sclk_out(sclk2), .sync_n(sync2),
    .done(done2), .busy(busy2)
  );

  // Cycle numbering: the cycle sampled at a negedge is cyc+1, the edge that
  // ends it. A handshake seen in cycle t happens at edge t.
  task automatic wait_handshake(output int t);
    int n = 0;
    t = -1;
    while (t < 0 && n < 60) begin
      #1;
      if (valid && ready) t = cyc + 1;
      else begin @(negedge clk); n++; end
    end
    total++;
    if (t < 0) begin
      bad++;
      $display("FAIL handshake: in_ready=%b never accepted in_valid=%b", ready, valid);
    end
  endtask

  task automatic observe(input logic [W-1:0] w, input int t, input bit noise,
                         output int first_low, output int last_low);
    int off, low_cnt = 0, done_cnt = 0, done_cyc = -1, nrise = 0;
    int ready_early = 0, sdo_bad = 0, sclk_bad = 0, busy_bad = 0, rise_bad = 0;
    logic [W-1:0] got = '0;
    logic prev = 1'b0, exp_sdo, exp_sclk;
    first_low = -1;
    last_low  = -1;
    for (int cur = t + 1; cur <= t + FL + 2; cur++) begin
      @(negedge clk);
      off = cur - t - 1;
      exp_sdo  = 1'b0;
      exp_sclk = 1'b0;
      if (off < FL) begin
        exp_sdo  = w[W-1-off/D];
        exp_sclk = (off % D) >= D / 2;
      end
      if (sdo !== exp_sdo) sdo_bad++;
      if (sclk !== exp_sclk) sclk_bad++;
      if (busy !== (off <= FL)) busy_bad++;
      if (off <= FL && ready !== 1'b0) ready_early++;
      if (!sync_n) begin
        if (first_low < 0) first_low = cur;
        last_low = cur;
        low_cnt++;
      end
      if (sclk && !prev) begin
        if (nrise < W) got[W-1-nrise] = sdo;
        if (cur != t + 1 + nrise * D + D / 2) rise_bad++;
        nrise++;
      end
      prev = sclk;
      if (done) begin done_cnt++; done_cyc = cur; end
      if (noise && off < FL) begin
        data  = W'($urandom);
        valid = 1'($urandom);
      end else if (noise) valid = 1'b0;
    end
    total += 12;
    if (got !== w) begin bad++; $display("FAIL bits: got %h want %h", got, w); end
    if (nrise != W) begin bad++; $display("FAIL rises: got %0d want %0d", nrise, W); end
    if (rise_bad != 0) begin bad++; $display("FAIL rise_pos: %0d misplaced rises", rise_bad); end
    if (low_cnt != FL) begin bad++; $display("FAIL sync_len: got %0d want %0d", low_cnt, FL); end
    if (first_low != t + 1) begin bad++; $display("FAIL sync_start: got %0d want %0d", first_low, t + 1); end
    if (done_cnt != 1) begin bad++; $display("FAIL done_cnt: got %0d want 1", done_cnt); end
    if (done_cyc != t + FL + 1) begin bad++; $display("FAIL done_cyc: got %0d want %0d", done_cyc, t + FL + 1); end
    if (ready !== 1'b1) begin bad++; $display("FAIL ready_back: got %b want 1", ready); end
    if (ready_early != 0) begin bad++; $display("FAIL ready_busy: high %0d cycles, want 0", ready_early); end
    if (sdo_bad != 0) begin bad++; $display("FAIL sdo: %0d wrong cycles for %h", sdo_bad, w); end
    if (sclk_bad != 0) begin bad++; $display("FAIL sclk: %0d wrong cycles", sclk_bad); end
    if (busy_bad != 0) begin bad++; $display("FAIL busy: %0d wrong cycles", busy_bad); end
  endtask

  task automatic send(input logic [W-1:0] w, input bit noise);
    int t, f, l;
    @(negedge clk);
    data  = w;
    valid = 1'b1;
    wait_handshake(t);
    if (t < 0) begin valid = 1'b0; return; end
    @(posedge clk); #1;
    valid = 1'b0;
    data  = ~w;
    observe(w, t, noise, f, l);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total += 7;
    if (sdo !== 1'b0)    begin bad++; $display("FAIL rst_sdo: got %b want 0", sdo); end
    if (sclk !== 1'b0)   begin bad++; $display("FAIL rst_sclk: got %b want 0", sclk); end
    if (sync_n !== 1'b1) begin bad++; $display("FAIL rst_sync: got %b want 1", sync_n); end
    if (done !== 1'b0)   begin bad++; $display("FAIL rst_done: got %b want 0", done); end
    if (busy !== 1'b0)   begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    if (ready !== 1'b0)  begin bad++; $display("FAIL rst_ready: got %b want 0", ready); end
    if (sync2 !== 1'b1)  begin bad++; $display("FAIL rst_sync2: got %b want 1", sync2); end
    reset = 1'b0;
    #1;
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready: got %b want 1", ready); end
  endtask

  task automatic test_back_to_back;
    int t1, t2, f1, l1, f2, l2;
    @(negedge clk);
    data  = 8'h3C;
    valid = 1'b1;
    wait_handshake(t1);
    if (t1 < 0) begin valid = 1'b0; return; end
    @(posedge clk); #1;
    data = 8'hC3;
    observe(8'h3C, t1, 1'b0, f1, l1);
    wait_handshake(t2);
    if (t2 < 0) begin valid = 1'b0; return; end
    @(posedge clk); #1;
    valid = 1'b0;
    observe(8'hC3, t2, 1'b0, f2, l2);
    total += 2;
    if (t2 != t1 + FL + 2) begin bad++; $display("FAIL b2b_period: got %0d want %0d", t2 - t1, FL + 2); end
    if (f2 - l1 - 1 != 2) begin bad++; $display("FAIL b2b_gap: got %0d want 2", f2 - l1 - 1); end
  endtask

  task automatic test_hold_off;
    int stray = 0;
    send(8'h81, 1'b1);
    repeat (6) begin
      @(negedge clk);
      if (sync_n !== 1'b1 || busy !== 1'b0) stray++;
    end
    total++;
    if (stray != 0) begin bad++; $display("FAIL hold_off: %0d cycles of stray frame", stray); end
  endtask

  task automatic test_reset_midframe;
    int t, spur = 0;
    @(negedge clk);
    data  = W'($urandom);
    valid = 1'b1;
    wait_handshake(t);
    if (t < 0) begin valid = 1'b0; return; end
    @(posedge clk); #1;
    valid = 1'b0;
    do @(negedge clk); while (cyc + 1 < t + 10);
    reset = 1'b1;
    @(negedge clk);
    total += 5;
    if (sync_n !== 1'b1) begin bad++; $display("FAIL abort_sync: got %b want 1", sync_n); end
    if (sclk !== 1'b0)   begin bad++; $display("FAIL abort_sclk: got %b want 0", sclk); end
    if (sdo !== 1'b0)    begin bad++; $display("FAIL abort_sdo: got %b want 0", sdo); end
    if (busy !== 1'b0)   begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
    if (done !== 1'b0)   begin bad++; $display("FAIL abort_done: got %b want 0", done); end
    reset = 1'b0;
    #1;
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL abort_ready: got %b want 1", ready); end
    repeat (FL) begin
      @(negedge clk);
      if (done || !sync_n) spur++;
    end
    total++;
    if (spur != 0) begin bad++; $display("FAIL abort_residue: %0d cycles of done/sync activity", spur); end
  endtask

  task automatic test_small;
    int t, off, sclk_bad = 0, sdo_bad = 0, done_bad = 0, ready_bad = 0;
    logic [1:0] w2;
    w2 = 2'b10;
    @(negedge clk);
    data2  = w2;
    valid2 = 1'b1;
    #1;
    total++;
    if (ready2 !== 1'b1) begin bad++; $display("FAIL small_ready: got %b want 1", ready2); end
    t = cyc + 1;
    @(posedge clk); #1;
    valid2 = 1'b0;
    for (int cur = t + 1; cur <= t + 6; cur++) begin
      @(negedge clk);
      off = cur - t - 1;
      if (sclk2 !== (off < 4 && off % 2 == 1)) sclk_bad++;
      if (sdo2 !== ((off < 4) ? w2[1-off/2] : 1'b0)) sdo_bad++;
      if (done2 !== (off == 4)) done_bad++;
      if (ready2 !== (off == 5)) ready_bad++;
    end
    total += 4;
    if (sclk_bad != 0)  begin bad++; $display("FAIL small_sclk: %0d wrong cycles", sclk_bad); end
    if (sdo_bad != 0)   begin bad++; $display("FAIL small_sdo: %0d wrong cycles", sdo_bad); end
    if (done_bad != 0)  begin bad++; $display("FAIL small_done: %0d wrong cycles", done_bad); end
    if (ready_bad != 0) begin bad++; $display("FAIL small_ready_seq: %0d wrong cycles", ready_bad); end
  endtask

  initial begin
    test_reset;
    send(8'hA5, 1'b0);
    test_back_to_back;
    test_hold_off;
    send(8'h00, 1'b0);
    send(8'hFF, 1'b0);
    repeat (6) send(W'($urandom), 1'b0);
    test_reset_midframe;
    test_small;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
